// File: rtl/if_prefetch_buffer.sv
// Instruction-fetch stage: sequential fetch with one-cycle memory latency,
// DEPTH-entry prefetch FIFO feeding decode, redirect on flush.

module if_prefetch_buffer_chk #(
  parameter int unsigned CW    = 3,
  parameter int unsigned DEPTH = 4
) (
  input logic          Clock,
  input logic          Reset,
  input logic          push,
  input logic [CW-1:0] count
);
  localparam logic [CW-1:0] FULL = DEPTH[CW-1:0];

  a_no_overflow: assert property (@(posedge Clock) disable iff (Reset) !(push && (count == FULL)));
endmodule

module if_prefetch_buffer #(
  parameter int unsigned       XLEN      = 32,
  parameter int unsigned       DEPTH     = 4,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [XLEN-1:0]   NOP_INSTR = 32'h00000013
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     flush,
  input  logic [XLEN-1:0]          redirect_pc,
  input  logic                     hold,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  output logic [XLEN-1:0]          PC_out,
  output logic [XLEN-1:0]          instruction_out,
  output logic                     valid_out,
  output logic [$clog2(DEPTH):0]   count_out
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pc_pipe_q, pc_pipe_d;
  logic            inflight_q, inflight_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];

  logic [CW:0] credits_s;
  logic        issue_s, push_s, pop_s, bubble_s;

  // Credit accounting: buffered entries plus the one response that may be in flight.
  always_comb begin
    credits_s = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue_s   = !Reset && !flush && (credits_s < DEPTH_W);
    push_s    = inflight_q && !flush;
    pop_s     = !flush && !hold && (count_q != {CW{1'b0}});
    bubble_s  = flush || hold || (count_q == {CW{1'b0}});
  end

  // Next-state: a flush squashes the FIFO and the in-flight response and redirects.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_pipe_d  = pc_pipe_q;
    inflight_d = issue_s;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (flush) begin
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      rd_ptr_d   = {AW{1'b0}};
      wr_ptr_d   = {AW{1'b0}};
      count_d    = {CW{1'b0}};
    end else begin
      if (issue_s) begin
        fetch_pc_d = fetch_pc_q + {{(XLEN-3){1'b0}}, 3'b100};
        pc_pipe_d  = fetch_pc_q;
      end else begin
        pc_pipe_d  = pc_pipe_q;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fetch_pc_q <= RESET_PC;
      pc_pipe_q  <= RESET_PC;
      inflight_q <= 1'b0;
      rd_ptr_q   <= {AW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_pipe_q  <= pc_pipe_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage: response is paired with the PC captured when it was issued.
  always_ff @(posedge Clock) begin
    if (push_s && !Reset) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= pc_pipe_q;
    end
  end

  // Decode-facing outputs and fetch request.
  always_comb begin
    imem_req  = issue_s;
    imem_addr = fetch_pc_q;
    count_out = count_q;
    if (bubble_s) begin
      instruction_out = NOP_INSTR;
      PC_out          = {XLEN{1'b0}};
      valid_out       = 1'b0;
    end else begin
      instruction_out = instr_mem_q[rd_ptr_q];
      PC_out          = pc_mem_q[rd_ptr_q];
      valid_out       = 1'b1;
    end
  end

  if_prefetch_buffer_chk #(.CW(CW), .DEPTH(DEPTH)) u_chk (
    .Clock (Clock),
    .Reset (Reset),
    .push  (push_s),
    .count (count_q)
  );
endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Bench for if_prefetch_buffer: directed vector table, hand-written corner
// sequences and random traffic, all checked against a queue-based model.

module tb_if_prefetch_buffer;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] RST_PC = 32'h00000000;

  logic        Clock, Reset, flush, hold, imem_req, valid_out;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, PC_out, instruction_out;
  logic [2:0]  count_out;
  logic [31:0] mem_addr_q;

  int errors = 0;
  int checks = 0;

  if_prefetch_buffer #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .Clock(Clock), .Reset(Reset), .flush(flush), .redirect_pc(redirect_pc), .hold(hold),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .PC_out(PC_out), .instruction_out(instruction_out), .valid_out(valid_out),
    .count_out(count_out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE0001;
  endfunction

  // Instruction memory with one-cycle latency.
  always @(posedge Clock) mem_addr_q <= imem_addr;
  assign imem_rdata = mem_f(mem_addr_q);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of buffered PCs, one in-flight slot, fetch pointer.
  logic [31:0] q_pc[$];
  bit          m_infl;
  bit          m_req;
  logic [31:0] m_infl_pc, m_fpc;

  task automatic model_check();
    int sz = q_pc.size();
    m_req = !Reset && !flush && ((sz + int'(m_infl)) < DEPTH);
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
    if (m_req) chk("imem_addr", imem_addr, m_fpc);
    chk("count_out", {29'b0, count_out}, 32'(sz));
    if (flush || hold || sz == 0) begin
      chk("valid_out", {31'b0, valid_out}, 32'd0);
      chk("PC_out", PC_out, 32'd0);
      chk("instruction_out", instruction_out, NOP);
    end else begin
      chk("valid_out", {31'b0, valid_out}, 32'd1);
      chk("PC_out", PC_out, q_pc[0]);
      chk("instruction_out", instruction_out, mem_f(q_pc[0]));
    end
  endtask

  task automatic model_advance();
    if (Reset) begin
      q_pc.delete();
      m_infl = 1'b0;
      m_fpc  = RST_PC;
    end else if (flush) begin
      q_pc.delete();
      m_infl = 1'b0;
      m_fpc  = redirect_pc;
    end else begin
      if (!hold && q_pc.size() != 0) void'(q_pc.pop_front());
      if (m_infl) q_pc.push_back(m_infl_pc);
      m_infl    = m_req;
      m_infl_pc = m_fpc;
      if (m_req) m_fpc = m_fpc + 32'd4;
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic h, input logic [31:0] rp);
    Reset = r; flush = f; hold = h; redirect_pc = rp;
    #1;
    model_check();
  endtask

  task automatic tick();
    model_advance();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic step(input logic r, input logic f, input logic h, input logic [31:0] rp);
    drive(r, f, h, rp);
    tick();
  endtask

  typedef struct {
    logic        rst, fl, hd;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   3'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   3'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0,   3'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0,   3'd1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h0,   1'b1, 32'hC,   1'b0, 32'h0,   3'd1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0,   3'd2};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   3'd3};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   3'd4};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h4,   3'd4};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h8,   3'd3};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   3'd2};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   3'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0,   3'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100, 3'd1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h104, 3'd1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   3'd0};

    Reset = 1'b1; flush = 1'b0; hold = 1'b0; redirect_pc = 32'h0;
    q_pc.delete(); m_infl = 1'b0; m_req = 1'b0; m_fpc = RST_PC; m_infl_pc = RST_PC;
    repeat (3) @(posedge Clock);
    @(negedge Clock);

    // Directed vector table from reset through hold, flush and reset.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].hd, tbl[i].rpc);
      chk($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), {31'b0, valid_out}, {31'b0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_pc", i), PC_out, tbl[i].e_pc);
      chk($sformatf("tbl%0d_instr", i), instruction_out,
          tbl[i].e_valid ? mem_f(tbl[i].e_pc) : NOP);
      chk($sformatf("tbl%0d_count", i), {29'b0, count_out}, {29'b0, tbl[i].e_cnt});
      tick();
    end

    // Flush with three buffered entries and a request in flight.
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("pre_flush_count", {29'b0, count_out}, 32'd3);
    step(1'b0, 1'b1, 1'b0, 32'h00000100);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("post_flush_count", {29'b0, count_out}, 32'd0);
    chk("post_flush_addr", imem_addr, 32'h00000100);
    tick();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("post_flush_first_pc", PC_out, 32'h00000100);
    tick();
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);

    // Flush and hold together, last redirect wins.
    step(1'b0, 1'b1, 1'b1, 32'h00000180);
    step(1'b0, 1'b1, 1'b1, 32'h000001C0);
    step(1'b0, 1'b1, 1'b1, 32'h00000200);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("flush_hold_addr", imem_addr, 32'h00000200);
    tick();
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);

    // Reset mid-stream with a partly full FIFO.
    repeat (2) step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("pre_reset_count", {29'b0, count_out}, 32'd3);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("post_reset_count", {29'b0, count_out}, 32'd0);
    chk("post_reset_addr", imem_addr, RST_PC);
    tick();
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);

    // PC wrap through the top of the address space.
    step(1'b0, 1'b1, 1'b0, 32'hFFFFFFF8);
    repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h00000000);
    tick();
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      logic        r, f, h;
      logic [31:0] rp;
      r  = ($urandom % 50) == 0;
      f  = ($urandom % 16) == 0;
      h  = ($urandom % 4) == 0;
      rp = $urandom & 32'hFFFFFFFC;
      if (($urandom % 4) == 0) rp = 32'hFFFFFFF0 | (rp & 32'h0000000C);
      step(r, f, h, rp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
